mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single DPI load/store memory port between the instruction-fetch unit (IF) and the load/store unit (LS). It arbitrates round-robin, issues exactly one one-cycle strobe per accepted request, and waits for the memory's registered `ok` pulse. It returns a registered response to the winning requester, or an error response on timeout. It sits between IFU/LSU and the memory-access block.

## Interface
- `TIMEOUT`, 15: cycles waited in WAIT for `ok` before an error response is returned (≥1).
- `clock  in  1`: sole clock, rising edge.
- `reset  in  1`: asynchronous reset, active-low.
- `if_req_valid  in  1`: IF read request valid.
- `if_req_ready  out  1`: IF request accepted this cycle.
- `if_req_addr  in  32`: IF read address.
- `if_resp_valid  out  1`: one-cycle IF response pulse.
- `if_resp_data  out  32`: IF read data.
- `if_resp_err  out  1`: IF timeout flag.
- `ls_req_valid  in  1`: LS request valid.
- `ls_req_ready  out  1`: LS request accepted this cycle.
- `ls_req_wr  in  1`: 1 = store, 0 = load.
- `ls_req_addr  in  32`: LS address.
- `ls_req_wdata  in  32`: store data.
- `ls_req_wmask  in  8`: store byte mask.
- `ls_resp_valid  out  1`: one-cycle LS response pulse.
- `ls_resp_data  out  32`: load data; 0 for stores.
- `ls_resp_err  out  1`: LS timeout flag.
- `mem_ld_wen  out  1`: load strobe.
- `mem_st_wen  out  1`: store strobe.
- `mem_raddr  out  32`: load address.
- `mem_waddr  out  32`: store address.
- `mem_wdata  out  32`: store data.
- `mem_wmask  out  8`: store byte mask.
- `mem_rdata  in  32`: load data, valid with `mem_rdata_ok`.
- `mem_rdata_ok  in  1`: load complete.
- `mem_wdata_ok  in  1`: store complete.

## Operation
- **States.**
  - IDLE: arbitrate; accept at most one request.
  - ISSUE: drive one strobe for one cycle.
  - WAIT: wait for the matching `ok`, counting cycles.
  - RESP: drive the response pulse.
- **Transitions.**
  - IDLE→ISSUE on accept.
  - ISSUE→WAIT unconditionally.
  - WAIT→RESP on the matching `ok`, or when the counter reaches `TIMEOUT`.
  - RESP→IDLE unconditionally.
- **Ready.** `*_req_ready` is combinational and is asserted only in IDLE, only to the arbitration winner, only when that requester's valid is high. Never both at once.
- **Arbitration.**
  - A sole requester wins.
  - With both valid, the requester not granted last wins.
  - The `last_grant` register updates on every accept.
  - After reset, IF wins the first contention.
- **Request capture.** On accept, id, wr, addr, wdata and wmask are registered. Requesters hold their fields stable only until ready.
- **Strobes.**
  - In ISSUE, exactly one of `mem_ld_wen`/`mem_st_wen` is 1. IF is always a load.
  - Loads drive `mem_raddr`; waddr, wdata and wmask are 0.
  - Stores drive `mem_waddr`, `mem_wdata` and `mem_wmask`; raddr is 0.
  - Outside ISSUE, all `mem_*` outputs are 0.
- **Completion matching.**
  - Loads complete only on `mem_rdata_ok`; stores only on `mem_wdata_ok`.
  - `ok` pulses in any other state, or of the wrong kind, are ignored.
  - `mem_rdata` is captured on the completing cycle.
- **Timeout.**
  - The WAIT counter resets to 0 on entry and is `$clog2(TIMEOUT+1)` bits wide.
  - If the counter reaches `TIMEOUT` with no `ok`, the response has err=1 and data=0.
  - An `ok` arriving in the same cycle the counter reaches `TIMEOUT` wins: err=0.
- **Response.** In RESP, only the captured requester's `resp_valid` is 1, with data and err from registers. The other requester's response outputs stay 0. There is no response back-pressure.
- **Reset.**
  - Asynchronous: state→IDLE, `last_grant`→LS, counter→0.
  - All outputs read 0: ready, resp valid/data/err, and all `mem_*`.
  - A request in flight when reset asserts is dropped; no response is ever issued for it.

## Timing
- Accept in cycle N → strobe in N+1 → memory `ok` in N+2 (nominal) → `resp_valid` in N+3.
- Next accept no earlier than N+4. Peak throughput is one transaction per 4 cycles.
- Timeout path: `resp_valid` in cycle N+2+`TIMEOUT`.
- `ready` depends combinationally on `valid` and state only, with no path from `mem_*` inputs.
- All other outputs are registered or decoded from the registered state.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - requester id constants `REQ_IF=0`, `REQ_LS=1`;
  - `DEFAULT_TIMEOUT=15`.
- **Sub-module `rr_arb2`:** two-input round-robin grant.
  - Inputs: two valids, `last_grant`, enable.
  - Output: one-hot grant.

## Test plan
- **IF load, reset values.** Reset low then released; IF load at 0x8000_0000; memory returns 0xDEAD_BEEF one cycle after `ld_wen`. Required: all outputs 0 during reset; `if_resp_valid` 3 cycles after accept with data 0xDEAD_BEEF and err=0.
- **LS store.** Addr 0x8000_0010, wdata 0x1234_5678, wmask 0x0F. Required: single-cycle `st_wen` with these exact values and raddr=0; `ls_resp_valid` with data 0 and err=0.
- **Contention.** IF and LS both valid continuously for 4 transactions. Required: grants IF, LS, IF, LS; never both ready; accepts spaced 4 cycles apart.
- **Timeout.** Memory silent after a load strobe, `TIMEOUT`=15. Required: response at N+17 with err=1, data 0; a late `ok` in IDLE is ignored. Also `ok` on the timeout cycle → err=0.
- **Spurious `ok`.** `mem_wdata_ok` during a load WAIT. Required: no completion; completion occurs only on `mem_rdata_ok`.
- **Reset mid-operation.** Reset asserted during WAIT. Required: immediate IDLE with all outputs 0, no response after release, next request served normally with IF priority.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on contention the requester not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       en,
    input  logic       valid_if,
    input  logic       valid_ls,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid_if && (!valid_ls || last_grant == REQ_LS)) begin
                grant[0] = 1'b1;
            end else if (valid_ls) begin
                grant[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single load/store memory port between IF and LS: one strobe per
// accepted request, waits for the matching ok (or timeout), returns one response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_req_wr,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    input  logic [7:0]  ls_req_wmask,
    output logic        ls_resp_valid,
    output logic [31:0] ls_resp_data,
    output logic        ls_resp_err,
    output logic        mem_ld_wen,
    output logic        mem_st_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_ok,
    input  logic        mem_wdata_ok,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             last_grant;
    logic [1:0]       grant;
    logic             arb_en;
    logic             accept;
    logic             cap_id;
    logic             cap_wr;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic [7:0]       cap_wmask;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic             done;
    logic             expired;
    logic             issue;
    logic             in_resp;

    // Handshake: a request transfers in the cycle where valid and ready are both
    // high; ready is only offered in IDLE (and never while reset is held), to
    // the arbitration winner, and the requester may change its fields afterwards.
    assign arb_en = (state == S_IDLE) && reset;

    rr_arb2 u_rr_arb2 (
        .en         (arb_en),
        .valid_if   (if_req_valid),
        .valid_ls   (ls_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign if_req_ready = grant[0];
    assign ls_req_ready = grant[1];
    assign accept       = |grant;

    assign done    = (state == S_WAIT) && (cap_wr ? mem_wdata_ok : mem_rdata_ok);
    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_grant <= REQ_LS;
            cap_id     <= REQ_IF;
            cap_wr     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wmask  <= '0;
            cnt        <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_id     <= grant[1];
                        cap_wr     <= grant[1] & ls_req_wr;
                        cap_addr   <= grant[1] ? ls_req_addr : if_req_addr;
                        cap_wdata  <= (grant[1] & ls_req_wr) ? ls_req_wdata : 32'h0;
                        cap_wmask  <= (grant[1] & ls_req_wr) ? ls_req_wmask : 8'h0;
                        last_grant <= grant[1];
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A matching ok on the final counted cycle still completes cleanly.
                    if (done) begin
                        resp_data <= cap_wr ? 32'h0 : mem_rdata;
                        resp_err  <= 1'b0;
                        state     <= S_RESP;
                    end else if (expired) begin
                        resp_data <= 32'h0;
                        resp_err  <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign issue      = (state == S_ISSUE);
    assign mem_ld_wen = issue & ~cap_wr;
    assign mem_st_wen = issue & cap_wr;
    assign mem_raddr  = mem_ld_wen ? cap_addr  : 32'h0;
    assign mem_waddr  = mem_st_wen ? cap_addr  : 32'h0;
    assign mem_wdata  = mem_st_wen ? cap_wdata : 32'h0;
    assign mem_wmask  = mem_st_wen ? cap_wmask : 8'h0;

    assign in_resp       = (state == S_RESP);
    assign if_resp_valid = in_resp & (cap_id == REQ_IF);
    assign ls_resp_valid = in_resp & (cap_id == REQ_LS);
    assign if_resp_data  = if_resp_valid ? resp_data : 32'h0;
    assign if_resp_err   = if_resp_valid & resp_err;
    assign ls_resp_data  = ls_resp_valid ? resp_data : 32'h0;
    assign ls_resp_err   = ls_resp_valid & resp_err;

    assign dbg_state = state;

endmodule
